// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two per-source result queues with bypass,
// round-robin grant and a registered one-result-per-cycle broadcast.
module cdb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int ROB_ID_W = 4,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                valid_from_alu,
    input  logic [ROB_ID_W-1:0] rob_id_from_alu,
    input  logic [DATA_W-1:0]   result_from_alu,
    output logic                full_to_alu,
    input  logic                valid_from_ls,
    input  logic [ROB_ID_W-1:0] rob_id_from_ls,
    input  logic [DATA_W-1:0]   result_from_ls,
    output logic                full_to_ls,
    input  logic                rollback_flag_from_rob,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [DATA_W-1:0]   cdb_result
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LS  = 1'b1
    } src_e;

    // queue storage
    logic [ROB_ID_W-1:0] alu_id_q  [DEPTH];
    logic [DATA_W-1:0]   alu_dat_q [DEPTH];
    logic [ROB_ID_W-1:0] ls_id_q   [DEPTH];
    logic [DATA_W-1:0]   ls_dat_q  [DEPTH];

    logic [PTR_W-1:0] alu_head, alu_tail;
    logic [PTR_W-1:0] ls_head, ls_tail;
    logic [CNT_W-1:0] alu_cnt, ls_cnt;
    src_e             last_grant;

    logic                alu_acc, ls_acc;
    logic                alu_cand, ls_cand;
    logic                alu_has, ls_has;
    logic [ROB_ID_W-1:0] alu_cand_id, ls_cand_id;
    logic [DATA_W-1:0]   alu_cand_dat, ls_cand_dat;
    logic                win_alu, win_ls;
    logic                alu_pop, alu_push;
    logic                ls_pop, ls_push;
    logic                advance;

    assign full_to_alu = (alu_cnt == CNT_FULL);
    assign full_to_ls  = (ls_cnt == CNT_FULL);

    // normal operation happens only when not reset, not flushing and ready
    assign advance = !rst && !rollback_flag_from_rob && rdy;

    // accept, candidate selection and round-robin grant
    always_comb begin
        alu_acc  = valid_from_alu && (rob_id_from_alu != '0)
                   && (alu_cnt != CNT_FULL);
        ls_acc   = valid_from_ls && (rob_id_from_ls != '0)
                   && (ls_cnt != CNT_FULL);
        alu_has  = (alu_cnt != '0);
        ls_has   = (ls_cnt != '0);
        alu_cand = alu_has || alu_acc;
        ls_cand  = ls_has || ls_acc;

        alu_cand_id  = rob_id_from_alu;
        alu_cand_dat = result_from_alu;
        if (alu_has) begin
            alu_cand_id  = alu_id_q[alu_head];
            alu_cand_dat = alu_dat_q[alu_head];
        end

        ls_cand_id  = rob_id_from_ls;
        ls_cand_dat = result_from_ls;
        if (ls_has) begin
            ls_cand_id  = ls_id_q[ls_head];
            ls_cand_dat = ls_dat_q[ls_head];
        end

        win_alu = alu_cand;
        win_ls  = ls_cand;
        if (alu_cand && ls_cand) begin
            win_alu = (last_grant == SRC_LS);
            win_ls  = !win_alu;
        end

        // a bypassed input that wins is consumed; anything else accepted queues
        alu_pop  = win_alu && alu_has;
        alu_push = alu_acc && !(win_alu && !alu_has);
        ls_pop   = win_ls && ls_has;
        ls_push  = ls_acc && !(win_ls && !ls_has);
    end

    // pointers, counts, grant history and the registered broadcast
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_head   <= '0;
            alu_tail   <= '0;
            alu_cnt    <= '0;
            ls_head    <= '0;
            ls_tail    <= '0;
            ls_cnt     <= '0;
            last_grant <= SRC_LS;
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_result <= '0;
        end else if (rollback_flag_from_rob) begin
            alu_head   <= '0;
            alu_tail   <= '0;
            alu_cnt    <= '0;
            ls_head    <= '0;
            ls_tail    <= '0;
            ls_cnt     <= '0;
            last_grant <= SRC_LS;
            cdb_valid  <= 1'b0;
        end else if (rdy) begin
            if (alu_pop) begin
                alu_head <= alu_head + PTR_W'(1);
            end
            if (alu_push) begin
                alu_tail <= alu_tail + PTR_W'(1);
            end
            alu_cnt <= alu_cnt + CNT_W'(alu_push) - CNT_W'(alu_pop);

            if (ls_pop) begin
                ls_head <= ls_head + PTR_W'(1);
            end
            if (ls_push) begin
                ls_tail <= ls_tail + PTR_W'(1);
            end
            ls_cnt <= ls_cnt + CNT_W'(ls_push) - CNT_W'(ls_pop);

            if (alu_cand && ls_cand) begin
                last_grant <= win_alu ? SRC_ALU : SRC_LS;
            end

            cdb_valid <= win_alu || win_ls;
            if (win_alu) begin
                cdb_rob_id <= alu_cand_id;
                cdb_result <= alu_cand_dat;
            end else if (win_ls) begin
                cdb_rob_id <= ls_cand_id;
                cdb_result <= ls_cand_dat;
            end
        end
    end

    // queue payload writes at tail; storage itself needs no reset
    always_ff @(posedge clk) begin
        if (advance && alu_push) begin
            alu_id_q[alu_tail]  <= rob_id_from_alu;
            alu_dat_q[alu_tail] <= result_from_alu;
        end
        if (advance && ls_push) begin
            ls_id_q[ls_tail]  <= rob_id_from_ls;
            ls_dat_q[ls_tail] <= result_from_ls;
        end
    end

endmodule
